// File: rtl/wishbone_bus_if.sv
`default_nettype none
// ============================================================================
//  Module   : wishbone_bus_if
//  Purpose  : Bridges one OpenMIPS memory port (instruction fetch or data
//             access) onto a Wishbone B3 classic master bus. Holds the
//             pipeline through stallreq until the slave acks, parks read
//             data while the owning stage is frozen by another stall
//             source, and aborts the cycle on an exception flush or an
//             optional ack timeout.
//  Ports    : clk, rst (sync, active-low)
//             stall_i[5:0], flush_i          - pipeline control from ctrl
//             cpu_ce_i, cpu_addr_i[31:0], cpu_data_i[31:0],
//             cpu_we_i, cpu_sel_i[3:0]       - core-side request
//             cpu_data_o[31:0], stallreq     - core-side response
//             bus_err_o                      - 1-cycle timeout abort pulse
//             wishbone_data_i[31:0], wishbone_ack_i          - slave side
//             wishbone_addr_o/data_o/we_o/sel_o/stb_o/cyc_o  - master side
//  Revision : 1.0 - initial release
// ============================================================================
module wishbone_bus_if #(
    parameter int STALL_IDX = 1,
    parameter int TIMEOUT   = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [5:0]  stall_i,
    input  logic        flush_i,
    input  logic        cpu_ce_i,
    input  logic [31:0] cpu_addr_i,
    input  logic [31:0] cpu_data_i,
    input  logic        cpu_we_i,
    input  logic [3:0]  cpu_sel_i,
    output logic [31:0] cpu_data_o,
    output logic        stallreq,
    output logic        bus_err_o,
    input  logic [31:0] wishbone_data_i,
    input  logic        wishbone_ack_i,
    output logic [31:0] wishbone_addr_o,
    output logic [31:0] wishbone_data_o,
    output logic        wishbone_we_o,
    output logic [3:0]  wishbone_sel_o,
    output logic        wishbone_stb_o,
    output logic        wishbone_cyc_o
);

    localparam logic [1:0] c_IDLE       = 2'd0;
    localparam logic [1:0] c_BUSY       = 2'd1;
    localparam logic [1:0] c_WAIT_STALL = 2'd2;

    localparam logic       c_TO_EN      = (TIMEOUT != 0);
    // Terminal count: the abort edge follows the TIMEOUT-th BUSY cycle.
    localparam logic [7:0] c_TO_LAST    = 8'(TIMEOUT - 1);

    logic [1:0]  r_state;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic        r_we;
    logic [3:0]  r_sel;
    logic        r_cyc;      // drives both stb and cyc so they never diverge
    logic [31:0] r_rd_buf;
    logic [7:0]  r_wait_cnt;
    logic        r_bus_err;

    logic        w_stall_own;
    logic        w_timeout;
    logic        w_unused;

    assign w_stall_own = stall_i[STALL_IDX];
    assign w_timeout   = c_TO_EN && (r_wait_cnt == c_TO_LAST);
    assign w_unused    = ^stall_i;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state    <= c_IDLE;
            r_addr     <= 32'd0;
            r_wdata    <= 32'd0;
            r_we       <= 1'b0;
            r_sel      <= 4'd0;
            r_cyc      <= 1'b0;
            r_rd_buf   <= 32'd0;
            r_wait_cnt <= 8'd0;
            r_bus_err  <= 1'b0;
        end else begin
            r_bus_err <= 1'b0;
            case (r_state)
                c_IDLE: begin
                    if (cpu_ce_i && !flush_i) begin
                        r_addr     <= cpu_addr_i;
                        r_wdata    <= cpu_data_i;
                        r_we       <= cpu_we_i;
                        r_sel      <= cpu_sel_i;
                        r_cyc      <= 1'b1;
                        r_wait_cnt <= 8'd0;
                        r_state    <= c_BUSY;
                    end
                end
                c_BUSY: begin
                    if (flush_i) begin
                        // Flush outranks a coincident ack: the word is dropped.
                        r_addr  <= 32'd0;
                        r_wdata <= 32'd0;
                        r_we    <= 1'b0;
                        r_sel   <= 4'd0;
                        r_cyc   <= 1'b0;
                        r_state <= c_IDLE;
                    end else if (wishbone_ack_i) begin
                        r_addr  <= 32'd0;
                        r_wdata <= 32'd0;
                        r_we    <= 1'b0;
                        r_sel   <= 4'd0;
                        r_cyc   <= 1'b0;
                        if (!r_we) begin
                            r_rd_buf <= wishbone_data_i;
                        end
                        r_state <= w_stall_own ? c_WAIT_STALL : c_IDLE;
                    end else begin
                        if (r_wait_cnt != 8'hFF) begin
                            r_wait_cnt <= r_wait_cnt + 8'd1;
                        end
                        if (w_timeout) begin
                            r_addr    <= 32'd0;
                            r_wdata   <= 32'd0;
                            r_we      <= 1'b0;
                            r_sel     <= 4'd0;
                            r_cyc     <= 1'b0;
                            r_bus_err <= 1'b1;
                            r_state   <= c_IDLE;
                        end
                    end
                end
                c_WAIT_STALL: begin
                    if (flush_i) begin
                        r_rd_buf <= 32'd0;
                        r_state  <= c_IDLE;
                    end else if (!w_stall_own) begin
                        r_state <= c_IDLE;
                    end
                end
                default: r_state <= c_IDLE;
            endcase
        end
    end

    always_comb begin
        stallreq   = 1'b0;
        cpu_data_o = 32'd0;
        case (r_state)
            c_IDLE: begin
                stallreq = cpu_ce_i & ~flush_i;
            end
            c_BUSY: begin
                if (flush_i) begin
                    stallreq = 1'b0;
                end else if (wishbone_ack_i) begin
                    // Bypass the acked word so the core sees it with no extra latency.
                    cpu_data_o = r_we ? 32'd0 : wishbone_data_i;
                end else begin
                    stallreq = 1'b1;
                end
            end
            c_WAIT_STALL: begin
                cpu_data_o = r_rd_buf;
            end
            default: begin
                stallreq   = 1'b0;
                cpu_data_o = 32'd0;
            end
        endcase
    end

    assign wishbone_addr_o = r_addr;
    assign wishbone_data_o = r_wdata;
    assign wishbone_we_o   = r_we;
    assign wishbone_sel_o  = r_sel;
    assign wishbone_stb_o  = r_cyc;
    assign wishbone_cyc_o  = r_cyc;
    assign bus_err_o       = r_bus_err;

endmodule
`default_nettype wire
